gem_copad_matcher: RTL and testbench



---
 rtl/gem_copad_matcher.sv | 150 +++++++++++++++
 tb/tb_gem_copad_matcher.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gem_copad_matcher.sv
// GEM0/GEM1 co-pad finder: same-roll pad-interval overlap with tolerance against a short
// GEM1 history; two-stage pipeline, outputs valid two clocks after the inputs.
module gem_copad_matcher #(
  parameter int MXCLUSTERS    = 8,
  parameter int MXADRB        = 11,
  parameter int MXCNTB        = 3,
  parameter int MXCLSTB       = 14,
  parameter int PADS_PER_ROLL = 192,
  parameter int MXROLLS       = 8,
  parameter int MXFEB         = 24,
  parameter int MXDEPTH       = 3,
  parameter int MXCNTRB       = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [MXCLUSTERS*MXCLSTB-1:0] gem0_clusters,
  input  logic [MXCLUSTERS*MXCLSTB-1:0] gem1_clusters,
  input  logic [2:0]                    cfg_tolerance,
  input  logic [1:0]                    cfg_window,
  input  logic                          cnt_clr,
  output logic [MXCLUSTERS*MXCLSTB-1:0] clusters_out,
  output logic [MXCLUSTERS-1:0]         match,
  output logic [MXCLUSTERS*2-1:0]       match_age,
  output logic                          any_match,
  output logic [MXFEB-1:0]              active_feb_list,
  output logic [MXCNTRB-1:0]            match_count,
  output logic                          sump
);

  localparam int ROLLB = (MXROLLS > 1) ? $clog2(MXROLLS) : 1;
  localparam int FEBB  = MXADRB - 6;
  localparam int SPANB = MXADRB + 1;
  localparam logic [MXCLSTB-1:0] INVALID   = {{MXCNTB{1'b0}}, {MXADRB{1'b1}}};
  localparam logic [1:0]         DEPTH_MAX = 2'(MXDEPTH);

  typedef logic [MXCLSTB-1:0] clst_t;

  clst_t      g0_r [MXCLUSTERS];
  clst_t      hist [MXDEPTH+1][MXCLUSTERS];
  logic [2:0] tol_r;
  logic [1:0] win_r;

  logic [MXCLUSTERS-1:0]   match_nx;
  logic [MXCLUSTERS*2-1:0] age_nx;
  logic [MXFEB-1:0]        feb_nx;
  logic                    sump_nx;

  function automatic logic [MXADRB-1:0] adr_of(input clst_t c);
    return c[MXADRB-1:0];
  endfunction

  function automatic logic [MXCNTB-1:0] cnt_of(input clst_t c);
    return c[MXCLSTB-1 -: MXCNTB];
  endfunction

  function automatic logic is_valid(input clst_t c);
    return c[MXADRB-1 -: 2] != 2'b11;
  endfunction

  function automatic logic [FEBB-1:0] feb_of(input clst_t c);
    return c[MXADRB-1:6];
  endfunction

  // Comparator chain instead of a divider: roll is the number of roll boundaries at or below adr.
  function automatic logic [ROLLB-1:0] roll_of(input logic [MXADRB-1:0] adr);
    logic [ROLLB-1:0] r;
    r = '0;
    for (int k = 1; k < MXROLLS; k++)
      if (int'(adr) >= k * PADS_PER_ROLL) r = ROLLB'(k);
    return r;
  endfunction

  // Spans are one bit wider than the address and only ever added to, so pad 0 cannot underflow.
  function automatic logic pair_hit(input clst_t c0, input clst_t c1, input logic [2:0] tol);
    logic [SPANB-1:0] a_lo, a_hi, b_lo, b_hi, t;
    a_lo = {1'b0, adr_of(c0)};
    a_hi = a_lo + SPANB'(cnt_of(c0));
    b_lo = {1'b0, adr_of(c1)};
    b_hi = b_lo + SPANB'(cnt_of(c1));
    t    = SPANB'(tol);
    return is_valid(c0) && is_valid(c1) &&
           (roll_of(adr_of(c0)) == roll_of(adr_of(c1))) &&
           (a_lo <= b_hi + t) && (b_lo <= a_hi + t);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      tol_r <= '0;
      win_r <= '0;
      for (int i = 0; i < MXCLUSTERS; i++) begin
        g0_r[i] <= INVALID;
        for (int k = 0; k <= MXDEPTH; k++) hist[k][i] <= INVALID;
      end
    end else begin
      tol_r <= cfg_tolerance;
      win_r <= (int'(cfg_window) > MXDEPTH) ? DEPTH_MAX : cfg_window;
      for (int i = 0; i < MXCLUSTERS; i++) begin
        g0_r[i]    <= gem0_clusters[i*MXCLSTB +: MXCLSTB];
        hist[0][i] <= gem1_clusters[i*MXCLSTB +: MXCLSTB];
        for (int k = 1; k <= MXDEPTH; k++) hist[k][i] <= hist[k-1][i];
      end
    end
  end

  // Ages are scanned oldest first so the youngest matching slot leaves the final age.
  always_comb begin
    match_nx = '0;
    age_nx   = '0;
    feb_nx   = '0;
    sump_nx  = 1'b0;
    for (int i = 0; i < MXCLUSTERS; i++) begin
      for (int k = MXDEPTH; k >= 0; k--) begin
        for (int j = 0; j < MXCLUSTERS; j++) begin
          if (k <= int'(win_r) && pair_hit(g0_r[i], hist[k][j], tol_r)) begin
            match_nx[i]      = 1'b1;
            age_nx[i*2 +: 2] = 2'(k);
          end
        end
      end
      for (int f = 0; f < MXFEB; f++)
        if (match_nx[i] && int'(feb_of(g0_r[i])) == f) feb_nx[f] = 1'b1;
      sump_nx = sump_nx | (match_nx[i] && int'(feb_of(g0_r[i])) >= MXFEB);
    end
  end

  // The counter steps on the same edge that loads any_match, so it already includes the visible bx.
  always_ff @(posedge clock) begin
    if (reset) begin
      clusters_out    <= '0;
      match           <= '0;
      match_age       <= '0;
      any_match       <= 1'b0;
      active_feb_list <= '0;
      sump            <= 1'b0;
      match_count     <= '0;
    end else begin
      for (int i = 0; i < MXCLUSTERS; i++) clusters_out[i*MXCLSTB +: MXCLSTB] <= g0_r[i];
      match           <= match_nx;
      match_age       <= age_nx;
      any_match       <= |match_nx;
      active_feb_list <= feb_nx;
      sump            <= sump_nx;
      if (cnt_clr)
        match_count <= '0;
      else if (|match_nx && match_count != '1)
        match_count <= match_count + MXCNTRB'(1);
    end
  end

endmodule

// File: tb/tb_gem_copad_matcher.sv
// Directed bench for gem_copad_matcher: hand-computed vectors, checked two clocks after each bx.
module tb_gem_copad_matcher;

  localparam int NC   = 8;
  localparam int CW   = 14;
  localparam int NFEB = 24;
  localparam int CNTW = 16;
  localparam logic [CW-1:0] INV = {3'd0, 11'h7FF};

  logic              clock;
  logic              reset;
  logic [NC*CW-1:0]  gem0_clusters;
  logic [NC*CW-1:0]  gem1_clusters;
  logic [2:0]        cfg_tolerance;
  logic [1:0]        cfg_window;
  logic              cnt_clr;
  logic [NC*CW-1:0]  clusters_out;
  logic [NC-1:0]     match;
  logic [NC*2-1:0]   match_age;
  logic              any_match;
  logic [NFEB-1:0]   active_feb_list;
  logic [CNTW-1:0]   match_count;
  logic              sump;

  int compared   = 0;
  int mismatched = 0;
  logic [NC*CW-1:0] idle_bus;
  logic [NC*CW-1:0] b0;
  logic [NC*CW-1:0] b1;

  gem_copad_matcher dut (
    .clock           (clock),
    .reset           (reset),
    .gem0_clusters   (gem0_clusters),
    .gem1_clusters   (gem1_clusters),
    .cfg_tolerance   (cfg_tolerance),
    .cfg_window      (cfg_window),
    .cnt_clr         (cnt_clr),
    .clusters_out    (clusters_out),
    .match           (match),
    .match_age       (match_age),
    .any_match       (any_match),
    .active_feb_list (active_feb_list),
    .match_count     (match_count),
    .sump            (sump)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #10000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [CW-1:0] clst(input int cnt, input int adr);
    return {3'(cnt), 11'(adr)};
  endfunction

  function automatic logic [NC*CW-1:0] put(input logic [NC*CW-1:0] bus, input int idx,
                                           input logic [CW-1:0] word);
    logic [NC*CW-1:0] r;
    r = bus;
    r[idx*CW +: CW] = word;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [NC*CW-1:0] g0, input logic [NC*CW-1:0] g1,
                               input logic [2:0] tol, input logic [1:0] win);
    gem0_clusters = g0;
    gem1_clusters = g1;
    cfg_tolerance = tol;
    cfg_window    = win;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One bx of stimulus followed by an idle bx, leaving its results on the outputs.
  task automatic oneBx(input logic [NC*CW-1:0] g0, input logic [NC*CW-1:0] g1,
                       input logic [2:0] tol, input logic [1:0] win);
    applyStimulus(g0, g1, tol, win);
    tick();
    applyStimulus(idle_bus, idle_bus, tol, win);
    tick();
  endtask

  initial begin
    idle_bus = {NC{INV}};
    cnt_clr  = 1'b0;
    reset    = 1'b1;
    applyStimulus(idle_bus, idle_bus, 3'd0, 2'd0);
    tick();
    tick();
    checkOutput("rst_match", 32'(match), 32'h0);
    checkOutput("rst_any", 32'(any_match), 32'h0);
    checkOutput("rst_feb", 32'(active_feb_list), 32'h0);
    checkOutput("rst_count", 32'(match_count), 32'h0);
    checkOutput("rst_clout", 32'(clusters_out[CW-1:0]), 32'h0);
    reset = 1'b0;
    tick();

    // exact match
    b0 = put(idle_bus, 0, clst(3, 100));
    b1 = put(idle_bus, 5, clst(3, 100));
    oneBx(b0, b1, 3'd0, 2'd0);
    checkOutput("t1_match", 32'(match), 32'h01);
    checkOutput("t1_age", 32'(match_age), 32'h0);
    checkOutput("t1_any", 32'(any_match), 32'h1);
    checkOutput("t1_feb", 32'(active_feb_list), 32'h000002);
    checkOutput("t1_count", 32'(match_count), 32'h1);
    checkOutput("t1_clout", 32'(clusters_out[CW-1:0]), 32'(clst(3, 100)));
    tick();
    checkOutput("t1_idle_match", 32'(match), 32'h0);
    checkOutput("t1_idle_count", 32'(match_count), 32'h1);

    // overlap, tolerance, partition edge, pad 0
    b0 = put(idle_bus, 0, clst(1, 200));
    b1 = put(idle_bus, 0, clst(0, 204));
    oneBx(b0, b1, 3'd0, 2'd0);
    checkOutput("t2_gap_tol0", 32'(match), 32'h0);
    oneBx(b0, b1, 3'd1, 2'd0);
    checkOutput("t2_gap_tol1", 32'(match), 32'h0);
    oneBx(b0, b1, 3'd3, 2'd0);
    checkOutput("t2_gap_tol3", 32'(match), 32'h01);
    b0 = put(idle_bus, 0, clst(2, 190));
    b1 = put(idle_bus, 0, clst(0, 192));
    oneBx(b0, b1, 3'd4, 2'd0);
    checkOutput("t2_roll_edge", 32'(match), 32'h0);
    b0 = put(idle_bus, 0, clst(0, 188));
    b1 = put(idle_bus, 0, clst(0, 190));
    oneBx(b0, b1, 3'd2, 2'd0);
    checkOutput("t2_same_roll", 32'(match), 32'h01);
    b0 = put(idle_bus, 0, clst(0, 0));
    b1 = put(idle_bus, 0, clst(0, 3));
    oneBx(b0, b1, 3'd3, 2'd0);
    checkOutput("t2_pad0", 32'(match), 32'h01);
    checkOutput("t2_count", 32'(match_count), 32'h4);

    // one GEM1 cluster matching several GEM0 clusters
    b0 = put(idle_bus, 0, clst(0, 300));
    b0 = put(b0, 3, clst(1, 299));
    b0 = put(b0, 7, clst(0, 1000));
    b1 = put(idle_bus, 2, clst(0, 300));
    oneBx(b0, b1, 3'd0, 2'd0);
    checkOutput("multi_match", 32'(match), 32'h09);
    checkOutput("multi_feb", 32'(active_feb_list), 32'h000010);
    checkOutput("multi_clout7", 32'(clusters_out[7*CW +: CW]), 32'(clst(0, 1000)));
    checkOutput("multi_count", 32'(match_count), 32'h5);

    // history window: GEM1 two bx older than GEM0
    b0 = put(idle_bus, 0, clst(0, 500));
    b1 = put(idle_bus, 0, clst(0, 500));
    applyStimulus(idle_bus, b1, 3'd0, 2'd1);
    tick();
    applyStimulus(idle_bus, idle_bus, 3'd0, 2'd1);
    tick();
    oneBx(b0, idle_bus, 3'd0, 2'd1);
    checkOutput("t3_win1", 32'(match), 32'h0);
    applyStimulus(idle_bus, b1, 3'd0, 2'd2);
    tick();
    applyStimulus(idle_bus, idle_bus, 3'd0, 2'd2);
    tick();
    oneBx(b0, idle_bus, 3'd0, 2'd2);
    checkOutput("t3_win2_match", 32'(match), 32'h01);
    checkOutput("t3_win2_age", 32'(match_age[1:0]), 32'h2);
    checkOutput("t3_win2_feb", 32'(active_feb_list), 32'h000080);
    applyStimulus(idle_bus, b1, 3'd0, 2'd3);
    tick();
    applyStimulus(idle_bus, b1, 3'd0, 2'd3);
    tick();
    oneBx(b0, idle_bus, 3'd0, 2'd3);
    checkOutput("t3_win3_match", 32'(match), 32'h01);
    checkOutput("t3_win3_age", 32'(match_age[1:0]), 32'h1);
    checkOutput("t3_count", 32'(match_count), 32'h7);

    // invalid clusters never match, even with identical addresses
    b0 = put(idle_bus, 1, clst(2, 'h600));
    b1 = put(idle_bus, 1, clst(2, 'h600));
    oneBx(b0, b1, 3'd7, 2'd3);
    checkOutput("t4_match", 32'(match), 32'h0);
    checkOutput("t4_feb", 32'(active_feb_list), 32'h0);
    checkOutput("t4_count", 32'(match_count), 32'h7);

    // saturation, then clear taking priority over a live match
    b0 = put(idle_bus, 0, clst(0, 100));
    b1 = put(idle_bus, 0, clst(0, 100));
    applyStimulus(b0, b1, 3'd0, 2'd0);
    for (int n = 0; n < 65541; n++) tick();
    checkOutput("t5_saturate", 32'(match_count), 32'hFFFF);
    checkOutput("t5_any", 32'(any_match), 32'h1);
    cnt_clr = 1'b1;
    tick();
    checkOutput("t5_clear", 32'(match_count), 32'h0);
    cnt_clr = 1'b0;
    tick();
    checkOutput("t5_restart", 32'(match_count), 32'h1);
    applyStimulus(idle_bus, idle_bus, 3'd0, 2'd0);
    tick();
    tick();
    tick();

    // reset mid-stream flushes the GEM1 history
    b0 = put(idle_bus, 0, clst(0, 64));
    b1 = put(idle_bus, 0, clst(0, 64));
    applyStimulus(idle_bus, b1, 3'd0, 2'd3);
    tick();
    reset = 1'b1;
    applyStimulus(idle_bus, idle_bus, 3'd0, 2'd3);
    tick();
    checkOutput("t6_rst_match", 32'(match), 32'h0);
    checkOutput("t6_rst_any", 32'(any_match), 32'h0);
    checkOutput("t6_rst_count", 32'(match_count), 32'h0);
    checkOutput("t6_rst_clout", 32'(clusters_out[CW-1:0]), 32'h0);
    reset = 1'b0;
    oneBx(b0, idle_bus, 3'd0, 2'd3);
    checkOutput("t6_after_match", 32'(match), 32'h0);
    checkOutput("t6_after_count", 32'(match_count), 32'h0);
    applyStimulus(idle_bus, b1, 3'd0, 2'd3);
    tick();
    applyStimulus(idle_bus, idle_bus, 3'd0, 2'd3);
    tick();
    oneBx(b0, idle_bus, 3'd0, 2'd3);
    checkOutput("t6_ctrl_match", 32'(match), 32'h01);
    checkOutput("t6_ctrl_age", 32'(match_age[1:0]), 32'h2);
    checkOutput("t6_ctrl_feb", 32'(active_feb_list), 32'h000002);
    checkOutput("t6_ctrl_count", 32'(match_count), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
